// File: rtl/riscv_pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, flush and a one-deep skid entry.
// o_ready comes straight from a flop, so downstream backpressure never reaches upstream combinationally.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_reg_skid #(
    parameter int unsigned     XLEN          = `XLEN,
    parameter int unsigned     NUM_CH        = 15,
    parameter logic [XLEN-1:0] REGISTER_INIT = {XLEN{1'b0}}
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NUM_CH*XLEN-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [NUM_CH*XLEN-1:0] o_data,
    output logic                   o_full
);

    localparam int unsigned       DW       = NUM_CH * XLEN;
    localparam logic [DW-1:0]     INIT_BUS = {NUM_CH{REGISTER_INIT}};

    // Encoding chosen so bit 0 is the main-valid flag and bit 1 the skid-valid flag.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   main_q,  main_d;
    logic [DW-1:0]   skid_q,  skid_d;
    logic            ready_q, ready_d;
    logic            in_fire_s;
    logic            out_fire_s;

    assign in_fire_s  = i_valid & ready_q;
    assign out_fire_s = state_q[0] & i_ready;

    assign o_ready = ready_q;
    assign o_valid = state_q[0];
    assign o_full  = state_q[1];
    assign o_data  = main_q;

    // Next-state and datapath selection; flush overrides every handshake event.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_clr) begin
            state_d = ST_EMPTY;
            main_d  = INIT_BUS;
            skid_d  = INIT_BUS;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_d  = i_data;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        main_d  = i_data;
                        state_d = ST_BUSY;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire_s) begin
                        skid_d  = i_data;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    // State and data registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= INIT_BUS;
            skid_q  <= INIT_BUS;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_riscv_pipe_reg_skid.sv
// Scoreboard bench for riscv_pipe_reg_skid: directed stimulus pushes expected beats,
// a monitor pops and compares on every output transfer.
module tb_riscv_pipe_reg_skid;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_CH = 15;
    localparam int unsigned DW     = XLEN * NUM_CH;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          o_ready, o_valid, o_full;
    logic [DW-1:0] o_data;
    logic          o13_ready, o13_valid, o13_full;
    logic [DW-1:0] o13_data;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    int            n_checks;
    int            n_pass;

    riscv_pipe_reg_skid #(.XLEN(XLEN), .NUM_CH(NUM_CH), .REGISTER_INIT(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(in_valid), .o_ready(o_ready),
        .i_data(in_data), .o_valid(o_valid), .i_ready(in_ready), .o_data(o_data), .o_full(o_full)
    );

    riscv_pipe_reg_skid #(.XLEN(XLEN), .NUM_CH(NUM_CH), .REGISTER_INIT(32'h0000_0013)) dut13 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(in_valid), .o_ready(o13_ready),
        .i_data(in_data), .o_valid(o13_valid), .i_ready(in_ready), .o_data(o13_data), .o_full(o13_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [XLEN-1:0] w);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int k = 0; k < NUM_CH; k++) r[k*XLEN +: XLEN] = w;
        return r;
    endfunction

    function automatic logic [DW-1:0] beat(input logic [XLEN-1:0] base);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int k = 0; k < NUM_CH; k++) r[k*XLEN +: XLEN] = base + k[XLEN-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_st(input string name, input logic v, input logic r, input logic f);
        check({name, ".o_valid"}, {{(DW-1){1'b0}}, o_valid}, {{(DW-1){1'b0}}, v});
        check({name, ".o_ready"}, {{(DW-1){1'b0}}, o_ready}, {{(DW-1){1'b0}}, r});
        check({name, ".o_full"},  {{(DW-1){1'b0}}, o_full},  {{(DW-1){1'b0}}, f});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && !clr && o_valid && in_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor: unexpected beat %h, scoreboard empty", o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_data === mon_exp) n_pass++;
                else $display("FAIL monitor: got %h expected %h", o_data, mon_exp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b1;
        in_ready = 1'b0;
        in_data  = rep(32'hDEAD_BEEF);

        // Reset with a valid input offered: nothing accepted.
        tick();
        tick();
        check_st("reset", 1'b0, 1'b1, 1'b0);
        check("reset.o_data", o_data, rep(32'h0000_0000));
        check("reset13.o_data", o13_data, rep(32'h0000_0013));
        check("reset13.status", {{(DW-3){1'b0}}, o13_valid, o13_ready, o13_full},
              {{(DW-3){1'b0}}, 1'b0, 1'b1, 1'b0});
        rst      = 1'b0;
        in_valid = 1'b0;

        // Streaming at full rate.
        in_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_data  = beat(32'h100 * n);
            exp_q.push_back(beat(32'h100 * n));
            tick();
            check_st($sformatf("stream%0d", n), 1'b1, 1'b1, 1'b0);
            check($sformatf("stream%0d.o_data", n), o_data, beat(32'h100 * n));
        end
        in_valid = 1'b0;
        tick();
        check_st("stream_end", 1'b0, 1'b1, 1'b0);
        check("stream_end.hold", o_data, beat(32'h300));

        // Backpressure into the skid entry.
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = beat(32'hA00);
        exp_q.push_back(beat(32'hA00));
        tick();
        in_data  = beat(32'hB00);
        exp_q.push_back(beat(32'hB00));
        tick();
        check_st("skid_full", 1'b1, 1'b0, 1'b1);
        check("skid_full.o_data", o_data, beat(32'hA00));
        in_data = beat(32'hC00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_st($sformatf("skid_hold%0d", c), 1'b1, 1'b0, 1'b1);
            check($sformatf("skid_hold%0d.o_data", c), o_data, beat(32'hA00));
        end
        in_ready = 1'b1;
        exp_q.push_back(beat(32'hC00));
        tick();
        check_st("skid_drain1", 1'b1, 1'b1, 1'b0);
        check("skid_drain1.o_data", o_data, beat(32'hB00));
        tick();
        in_valid = 1'b0;
        check("skid_drain2.o_data", o_data, beat(32'hC00));
        tick();
        check_st("skid_empty", 1'b0, 1'b1, 1'b0);

        // Flush while full: both stored beats and the offered one are dropped.
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = beat(32'hD00);
        exp_q.push_back(beat(32'hD00));
        tick();
        in_data  = beat(32'hE00);
        exp_q.push_back(beat(32'hE00));
        tick();
        check_st("pre_flush", 1'b1, 1'b0, 1'b1);
        clr     = 1'b1;
        in_data = beat(32'hF00);
        tick();
        exp_q.delete();
        clr      = 1'b0;
        in_valid = 1'b0;
        check_st("flush", 1'b0, 1'b1, 1'b0);
        check("flush.o_data", o_data, rep(32'h0000_0000));
        in_ready = 1'b1;
        tick();
        tick();
        check_st("post_flush", 1'b0, 1'b1, 1'b0);

        // Simultaneous accept and emit while BUSY.
        in_valid = 1'b1;
        in_data  = rep(32'h11);
        exp_q.push_back(rep(32'h11));
        tick();
        check("busy.o_data", o_data, rep(32'h11));
        in_data = rep(32'h22);
        exp_q.push_back(rep(32'h22));
        tick();
        check_st("busy_swap", 1'b1, 1'b1, 1'b0);
        check("busy_swap.o_data", o_data, rep(32'h22));
        in_valid = 1'b0;
        tick();

        // Drain to empty: data holds until reset.
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = rep(32'h55);
        exp_q.push_back(rep(32'h55));
        tick();
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        check_st("drain", 1'b0, 1'b1, 1'b0);
        check("drain.hold", o_data, rep(32'h55));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drain_rst.o_data", o_data, rep(32'h0000_0000));
        check("drain_rst13.o_data", o13_data, rep(32'h0000_0013));

        tick();
        check("scoreboard_empty", DW'(exp_q.size()), {DW{1'b0}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
